// File: rtl/mul_bus_ctrl.sv
// Bus-slave register front end for the 64x64 signed Booth multiplier core.
// Sequences the core's start/clear handshake and captures the 128-bit product.
module mul_bus_ctrl #(
    parameter int DW = 64,
    parameter int AW = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_sel,
    input  logic            s_wr,
    input  logic [AW-1:0]   s_addr,
    input  logic [DW-1:0]   s_din,
    output logic [DW-1:0]   s_dout,
    output logic            m_interrupt,
    output logic            mul_op_start,
    output logic            mul_op_clear,
    output logic [DW-1:0]   mul_multiplier,
    output logic [DW-1:0]   mul_multiplicand,
    input  logic            mul_op_done,
    input  logic [2*DW-1:0] mul_result
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        CLR  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [AW-1:0] ADDR_OPA    = AW'(0);
    localparam logic [AW-1:0] ADDR_OPB    = AW'(1);
    localparam logic [AW-1:0] ADDR_CTRL   = AW'(2);
    localparam logic [AW-1:0] ADDR_STATUS = AW'(3);
    localparam logic [AW-1:0] ADDR_RES_LO = AW'(4);
    localparam logic [AW-1:0] ADDR_RES_HI = AW'(5);

    state_t         state, state_next;
    logic [DW-1:0]  opa, opb, res_lo, res_hi;
    logic           ie, done_flag;
    logic           busy, bus_write, ctrl_write, start_cmd, clear_cmd;

    assign bus_write  = s_sel & s_wr;
    assign ctrl_write = bus_write && (s_addr == ADDR_CTRL);
    assign start_cmd  = ctrl_write & s_din[0];
    assign clear_cmd  = ctrl_write & s_din[1];
    assign busy       = (state == LOAD) || (state == RUN) || (state == CLR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Clear always beats start on the same write; op_done beats an abort in RUN.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_cmd && !clear_cmd) state_next = LOAD;
            LOAD: state_next = RUN;
            RUN: begin
                if (mul_op_done)    state_next = CLR;
                else if (clear_cmd) state_next = CLR;
            end
            CLR:  state_next = done_flag ? DONE : IDLE;
            DONE: begin
                if (clear_cmd)      state_next = IDLE;
                else if (start_cmd) state_next = LOAD;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opa       <= '0;
            opb       <= '0;
            res_lo    <= '0;
            res_hi    <= '0;
            ie        <= 1'b0;
            done_flag <= 1'b0;
        end else begin
            if (bus_write && (s_addr == ADDR_OPA) && !busy) opa <= s_din;
            if (bus_write && (s_addr == ADDR_OPB) && !busy) opb <= s_din;
            if (ctrl_write) ie <= s_din[2];
            if ((state == RUN) && mul_op_done) begin
                res_lo    <= mul_result[DW-1:0];
                res_hi    <= mul_result[2*DW-1:DW];
                done_flag <= 1'b1;
            end else if ((state == DONE) && (start_cmd || clear_cmd)) begin
                done_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        s_dout = '0;
        if (s_sel && !s_wr) begin
            case (s_addr)
                ADDR_OPA:    s_dout = opa;
                ADDR_OPB:    s_dout = opb;
                ADDR_CTRL:   s_dout = {{(DW-3){1'b0}}, ie, 2'b00};
                ADDR_STATUS: s_dout = {{(DW-3){1'b0}}, ie, done_flag, busy};
                ADDR_RES_LO: s_dout = res_lo;
                ADDR_RES_HI: s_dout = res_hi;
                default:     s_dout = '0;
            endcase
        end
    end

    assign mul_op_start     = (state == LOAD);
    assign mul_op_clear     = (state == CLR);
    assign mul_multiplier   = opa;
    assign mul_multiplicand = opb;
    assign m_interrupt      = done_flag & ie;

endmodule

// File: tb/tb_mul_bus_ctrl.sv
// Self-checking bench for mul_bus_ctrl with a behavioural 33-cycle multiplier core model.
module tb_mul_bus_ctrl;
    localparam int DW = 64;
    localparam int AW = 3;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            s_sel = 1'b0;
    logic            s_wr = 1'b0;
    logic [AW-1:0]   s_addr = '0;
    logic [DW-1:0]   s_din = '0;
    logic [DW-1:0]   s_dout;
    logic            m_interrupt;
    logic            mul_op_start, mul_op_clear;
    logic [DW-1:0]   mul_multiplier, mul_multiplicand;
    logic            mul_op_done;
    logic [2*DW-1:0] mul_result;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_lo, exp_hi;

    mul_bus_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr),
        .s_din(s_din), .s_dout(s_dout), .m_interrupt(m_interrupt),
        .mul_op_start(mul_op_start), .mul_op_clear(mul_op_clear),
        .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
        .mul_op_done(mul_op_done), .mul_result(mul_result)
    );

    always #5 clk = ~clk;

    // Core model: samples operands on op_start, raises op_done after 33 run cycles.
    logic signed [63:0] core_a, core_b;
    logic               core_busy;
    int                 core_cnt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_busy <= 1'b0; core_cnt <= 0; mul_op_done <= 1'b0; mul_result <= '0;
            core_a <= '0; core_b <= '0;
        end else begin
            mul_op_done <= 1'b0;
            if (mul_op_clear) begin
                core_busy <= 1'b0;
            end else if (mul_op_start) begin
                core_busy <= 1'b1; core_cnt <= 0;
                core_a <= mul_multiplier; core_b <= mul_multiplicand;
            end else if (core_busy) begin
                core_cnt <= core_cnt + 1;
                if (core_cnt + 1 == 33) begin
                    mul_op_done <= 1'b1;
                    mul_result  <= core_a * core_b;
                    core_busy   <= 1'b0;
                end
            end
        end
    end

    function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa, sb;
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        return sa * sb;
    endfunction

    task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        s_sel = 1'b1; s_wr = 1'b1; s_addr = a; s_din = d;
        @(posedge clk);
        @(negedge clk);
        s_sel = 1'b0; s_wr = 1'b0; s_din = '0;
    endtask

    task automatic bus_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
        s_sel = 1'b1; s_wr = 1'b0; s_addr = a;
        #1 d = s_dout;
        s_sel = 1'b0;
    endtask

    // Returns the cycle index (relative to the start write) at which done_flag is first seen, 0 on timeout.
    task automatic wait_done(input int k0, output int k);
        logic [DW-1:0] st;
        k = k0;
        forever begin
            bus_read(3'd3, st);
            if (st[1]) return;
            @(negedge clk);
            k++;
            if (k > 100) begin k = 0; return; end
        end
    endtask

    task automatic test_reset;
        logic [DW-1:0] v;
        reset_n = 1'b0;
        #2;
        checks++; if ({mul_op_start, mul_op_clear, m_interrupt} !== 3'b000) begin errors++; $display("[TB] FAIL reset_outputs got=%b want=000", {mul_op_start, mul_op_clear, m_interrupt}); end
        bus_read(3'd3, v);
        checks++; if (v !== 64'd0) begin errors++; $display("[TB] FAIL reset_status got=%h want=0", v); end
        bus_read(3'd0, v);
        checks++; if (v !== 64'd0) begin errors++; $display("[TB] FAIL reset_opa got=%h want=0", v); end
        bus_read(3'd5, v);
        checks++; if (v !== 64'd0) begin errors++; $display("[TB] FAIL reset_res_hi got=%h want=0", v); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [DW-1:0] v;
        int k;
        bus_write(3'd0, 64'd3);
        bus_write(3'd1, 64'd5);
        bus_write(3'd2, 64'd1);
        checks++; if (mul_op_start !== 1'b1) begin errors++; $display("[TB] FAIL basic_start_pulse got=%b want=1", mul_op_start); end
        bus_read(3'd3, v);
        checks++; if (v[0] !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy got=%b want=1", v[0]); end
        @(negedge clk);
        checks++; if (mul_op_start !== 1'b0) begin errors++; $display("[TB] FAIL basic_start_width got=%b want=0", mul_op_start); end
        wait_done(2, k);
        checks++; if (k < 35 || k > 37) begin errors++; $display("[TB] FAIL basic_latency got=%0d want=36+/-1", k); end
        exp_lo = 64'd15; exp_hi = 64'd0;
        bus_read(3'd4, v);
        checks++; if (v !== exp_lo) begin errors++; $display("[TB] FAIL basic_res_lo got=%h want=%h", v, exp_lo); end
        bus_read(3'd5, v);
        checks++; if (v !== exp_hi) begin errors++; $display("[TB] FAIL basic_res_hi got=%h want=%h", v, exp_hi); end
        checks++; if (m_interrupt !== 1'b0) begin errors++; $display("[TB] FAIL basic_irq_masked got=%b want=0", m_interrupt); end
        repeat (2) @(negedge clk);
        bus_read(3'd3, v);
        checks++; if (v !== 64'd2) begin errors++; $display("[TB] FAIL basic_status_done got=%h want=2", v); end
    endtask

    task automatic test_interrupt;
        logic [DW-1:0] v;
        int k;
        bus_write(3'd0, -64'sd2);
        bus_write(3'd1, 64'd7);
        bus_write(3'd2, 64'd5);
        wait_done(1, k);
        checks++; if (k < 35 || k > 37) begin errors++; $display("[TB] FAIL irq_latency got=%0d want=36+/-1", k); end
        {exp_hi, exp_lo} = ref_mul(-64'sd2, 64'd7);
        bus_read(3'd4, v);
        checks++; if (v !== exp_lo) begin errors++; $display("[TB] FAIL irq_res_lo got=%h want=%h", v, exp_lo); end
        bus_read(3'd5, v);
        checks++; if (v !== exp_hi) begin errors++; $display("[TB] FAIL irq_res_hi got=%h want=%h", v, exp_hi); end
        checks++; if (m_interrupt !== 1'b1) begin errors++; $display("[TB] FAIL irq_high got=%b want=1", m_interrupt); end
        bus_write(3'd2, 64'd6);
        checks++; if (m_interrupt !== 1'b0) begin errors++; $display("[TB] FAIL irq_cleared got=%b want=0", m_interrupt); end
        bus_read(3'd3, v);
        checks++; if (v !== 64'd4) begin errors++; $display("[TB] FAIL irq_status_idle got=%h want=4", v); end
        bus_read(3'd2, v);
        checks++; if (v !== 64'd4) begin errors++; $display("[TB] FAIL irq_ctrl_read got=%h want=4", v); end
    endtask

    task automatic test_min_value;
        logic [DW-1:0] v;
        int k;
        bus_write(3'd0, 64'h8000_0000_0000_0000);
        bus_write(3'd1, 64'h8000_0000_0000_0000);
        bus_write(3'd2, 64'd5);
        wait_done(1, k);
        checks++; if (k < 35 || k > 37) begin errors++; $display("[TB] FAIL min_latency got=%0d want=36+/-1", k); end
        exp_hi = 64'h4000_0000_0000_0000; exp_lo = 64'd0;
        bus_read(3'd4, v);
        checks++; if (v !== exp_lo) begin errors++; $display("[TB] FAIL min_res_lo got=%h want=%h", v, exp_lo); end
        bus_read(3'd5, v);
        checks++; if (v !== exp_hi) begin errors++; $display("[TB] FAIL min_res_hi got=%h want=%h", v, exp_hi); end
        @(negedge clk);
    endtask

    task automatic test_abort;
        logic [DW-1:0] v;
        bus_write(3'd2, 64'd5);
        repeat (4) @(negedge clk);
        bus_write(3'd0, 64'd9);
        bus_write(3'd2, 64'd5);
        @(negedge clk);
        bus_write(3'd2, 64'd6);
        checks++; if (mul_op_clear !== 1'b1) begin errors++; $display("[TB] FAIL abort_clear_pulse got=%b want=1", mul_op_clear); end
        @(negedge clk);
        checks++; if (mul_op_clear !== 1'b0) begin errors++; $display("[TB] FAIL abort_clear_width got=%b want=0", mul_op_clear); end
        bus_read(3'd0, v);
        checks++; if (v !== 64'h8000_0000_0000_0000) begin errors++; $display("[TB] FAIL abort_opa_frozen got=%h want=8000000000000000", v); end
        repeat (40) @(negedge clk);
        bus_read(3'd3, v);
        checks++; if (v !== 64'd4) begin errors++; $display("[TB] FAIL abort_status got=%h want=4", v); end
        bus_read(3'd4, v);
        checks++; if (v !== exp_lo) begin errors++; $display("[TB] FAIL abort_res_lo got=%h want=%h", v, exp_lo); end
        bus_read(3'd5, v);
        checks++; if (v !== exp_hi) begin errors++; $display("[TB] FAIL abort_res_hi got=%h want=%h", v, exp_hi); end
    endtask

    task automatic test_random;
        logic [DW-1:0] v, a, b;
        int k;
        for (int i = 0; i < 4; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i == 0) a[63] = 1'b1;
            bus_write(3'd0, a);
            bus_write(3'd1, b);
            bus_write(3'd2, 64'd1);
            wait_done(1, k);
            checks++; if (k < 35 || k > 37) begin errors++; $display("[TB] FAIL rand_latency[%0d] got=%0d want=36+/-1", i, k); end
            {exp_hi, exp_lo} = ref_mul(a, b);
            bus_read(3'd4, v);
            checks++; if (v !== exp_lo) begin errors++; $display("[TB] FAIL rand_res_lo[%0d] got=%h want=%h", i, v, exp_lo); end
            bus_read(3'd5, v);
            checks++; if (v !== exp_hi) begin errors++; $display("[TB] FAIL rand_res_hi[%0d] got=%h want=%h", i, v, exp_hi); end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] v;
        int k;
        bus_write(3'd0, 64'd6);
        bus_write(3'd1, 64'd7);
        bus_write(3'd2, 64'd1);
        bus_read(3'd3, v);
        checks++; if (v[1:0] !== 2'b01) begin errors++; $display("[TB] FAIL b2b_done_drop got=%b want=01", v[1:0]); end
        wait_done(1, k);
        checks++; if (k < 35 || k > 37) begin errors++; $display("[TB] FAIL b2b_latency got=%0d want=36+/-1", k); end
        bus_read(3'd4, v);
        checks++; if (v !== 64'd42) begin errors++; $display("[TB] FAIL b2b_res_lo got=%h want=2a", v); end
        bus_read(3'd5, v);
        checks++; if (v !== 64'd0) begin errors++; $display("[TB] FAIL b2b_res_hi got=%h want=0", v); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        logic [DW-1:0] v;
        int k;
        bus_write(3'd0, 64'd11);
        bus_write(3'd1, 64'd13);
        bus_write(3'd2, 64'd5);
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({mul_op_start, mul_op_clear, m_interrupt} !== 3'b000) begin errors++; $display("[TB] FAIL rst_run_outputs got=%b want=000", {mul_op_start, mul_op_clear, m_interrupt}); end
        checks++; if (mul_multiplier !== 64'd0) begin errors++; $display("[TB] FAIL rst_run_multiplier got=%h want=0", mul_multiplier); end
        bus_read(3'd3, v);
        checks++; if (v !== 64'd0) begin errors++; $display("[TB] FAIL rst_run_status got=%h want=0", v); end
        bus_read(3'd4, v);
        checks++; if (v !== 64'd0) begin errors++; $display("[TB] FAIL rst_run_res_lo got=%h want=0", v); end
        @(negedge clk);
        reset_n = 1'b1;
        bus_write(3'd0, 64'd3);
        bus_write(3'd1, 64'd5);
        bus_write(3'd2, 64'd1);
        wait_done(1, k);
        checks++; if (k < 35 || k > 37) begin errors++; $display("[TB] FAIL rst_rerun_latency got=%0d want=36+/-1", k); end
        bus_read(3'd4, v);
        checks++; if (v !== 64'd15) begin errors++; $display("[TB] FAIL rst_rerun_res_lo got=%h want=f", v); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_interrupt;
        test_min_value;
        test_abort;
        test_random;
        test_back_to_back;
        test_reset_mid_run;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
